button_bank: RTL and testbench
==============================

# button_bank

Parametrised, multi-channel successor to the single-button conditioner. It synchronises, debounces and edge-detects `N_BTN` raw pushbutton inputs in one block. Each channel produces a debounced level, one-cycle press and release pulses, and an optional hold-to-repeat pulse train for cursor navigation. It sits between the board pushbuttons and the Sudoku game controller, which consumes `action` as "move/step once".

## Interface
- `N_BTN`, 5, number of button channels.
- `DEBOUNCE_CYCLES`, 1_500_000, consecutive differing cycles required before `level` changes; ≥ 2.
- `REPEAT_DELAY`, 50_000_000, cycles from the press pulse to the first repeat pulse; ≥ 2.
- `REPEAT_PERIOD`, 10_000_000, cycles between subsequent repeat pulses; ≥ 2.
- `REPEAT_MASK`, all ones, per-channel auto-repeat enable (`N_BTN` bits).

- `clk`, in, 1, system clock.
- `reset`, in, 1, synchronous, active-high reset.
- `btn_in`, in, `N_BTN`, raw asynchronous button inputs.
- `level`, out, `N_BTN`, debounced button state.
- `press`, out, `N_BTN`, one-cycle pulse on a debounced rising edge.
- `release`, out, `N_BTN`, one-cycle pulse on a debounced falling edge.
- `repeat_pulse`, out, `N_BTN`, one-cycle auto-repeat pulse.
- `action`, out, `N_BTN`, `press | repeat_pulse`.
- `any_press`, out, 1, OR-reduction of `press`.

## Operation
- **Per-channel synchroniser.** Two flops, `s1 <= btn_in[i]` and `s2 <= s1`.
- **Debounce counter.** `dcnt` width is `$clog2(DEBOUNCE_CYCLES)`.
  - On each edge where `s2 == level`: `dcnt <= 0`.
  - Otherwise, if `dcnt == DEBOUNCE_CYCLES-1`: `level <= s2` and `dcnt <= 0`.
  - Otherwise: `dcnt <= dcnt + 1`.
  - Any bounce back to `level` clears the count.
- **Press/release pulses.** These are registered and set on the same edge that flips `level`.
  - `press` is high in the first cycle `level` is 1.
  - `release` is high in the first cycle `level` is 0.
  - Both are cleared on the next edge.
- **Repeat FSM** (per channel, only when `REPEAT_MASK[i]`; otherwise it stays in IDLE). Counter `rcnt` width is `$clog2(max(REPEAT_DELAY, REPEAT_PERIOD))`.
  - **IDLE:** on the level-rise edge, go to HOLD with `rcnt <= 0`.
  - **HOLD:** `rcnt` increments each edge. At `rcnt == REPEAT_DELAY-1`, set `repeat_pulse`, set `rcnt <= 0`, go to RPT.
  - **RPT:** `rcnt` increments each edge. At `rcnt == REPEAT_PERIOD-1`, set `repeat_pulse` and set `rcnt <= 0`.
  - **HOLD/RPT, any edge where `level` falls:** go to IDLE and set `rcnt <= 0`. If the repeat would fire on the same edge, the release wins and no `repeat_pulse` is emitted.
- **Channel independence.** Channels are fully independent. Simultaneous presses on multiple channels produce simultaneous pulses.

## Timing
- **Reset values.** On reset, all of the following clear to 0: `s1`, `s2`, `dcnt`, `rcnt`, `level`, `press`, `release`, `repeat_pulse`, `action`, `any_press`. The FSM goes to IDLE.
- **Reset mid-operation.** Reset discards all in-progress counts.
- **Button held through reset.** The channel debounces afresh after reset deasserts and yields a `press`. It produces no `release` first.
- **Press latency.** `btn_in` changes and is sampled at edge k. `level`/`press` update at edge k+1+`DEBOUNCE_CYCLES`.
- **Repeat timing.**
  - The first `repeat_pulse` is exactly `REPEAT_DELAY` cycles after the `press` cycle.
  - Subsequent pulses are every `REPEAT_PERIOD` cycles.
- **Pulse spacing.** `press`, `release` and `repeat_pulse` are never high for two consecutive cycles on one channel.
- **Exclusivity.** `press` and `repeat_pulse` are never coincident.
- **Combinational outputs.** `action` and `any_press` are combinational from registered pulses, so they add no extra latency.

## Structure
- **Shared package `input_pkg`:** the repeat-state enum `rpt_state_t` {IDLE, HOLD, RPT} and default timing constants `DEBOUNCE_DEFAULT`, `REPEAT_DELAY_DEFAULT`, `REPEAT_PERIOD_DEFAULT`.
- **Sub-module `button_channel`:** one synchroniser, debouncer and repeat FSM. It takes a scalar `repeat_en` and is instantiated `N_BTN` times by a generate loop.
- **Top level:** contains only the `action` and `any_press` glue.

## Test plan
Bench parameters: `N_BTN`=3, `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3, `REPEAT_MASK`=3'b011.

1. Reset with `btn_in`=0 → all outputs 0. Hold ch0=1 from edge k → `level[0]` and `press[0]` rise at edge k+5. `press[0]` lasts 1 cycle.
2. Bounce ch0 1,1,1,0 repeating → `level[0]` stays 0 and no `press`. Then a steady 1 → `press` exactly 5 edges after the last bounce.
3. Hold ch1 for 20 cycles after `press` → `repeat_pulse[1]` at press+10, +13, +16, +19. `action[1]` shows all five pulses (press plus four repeats).
4. Hold ch2 (repeat disabled) for 30 cycles → one `press[2]` and no `repeat_pulse[2]`. On release, `release[2]` comes 5 edges after `btn_in` falls.
5. Release ch1 so that `level` falls on the edge a repeat was due → `release[1]`=1, `repeat_pulse[1]`=0. FSM returns to IDLE.
6. Press ch0 and ch1 on the same cycle, and assert `reset` mid-HOLD on ch0 → simultaneous `press`, `any_press`=1. After reset all outputs are 0. Ch0, still held, re-presses 6 edges after reset deasserts.

Source files
------------

// File: rtl/input_pkg.sv
// Shared definitions for the pushbutton conditioning blocks: repeat-state
// encoding, default timing constants and a small constant helper.
package input_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    RPT
  } rpt_state_t;

  // Defaults assume a 100 MHz system clock: 15 ms debounce, 0.5 s to first repeat, 10 Hz repeat
  localparam int DEBOUNCE_DEFAULT      = 1_500_000;
  localparam int REPEAT_DELAY_DEFAULT  = 50_000_000;
  localparam int REPEAT_PERIOD_DEFAULT = 10_000_000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One pushbutton channel: two-flop synchroniser, counting debouncer,
// registered press/release pulses and a hold-to-repeat state machine.
module button_channel
  import input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  input  logic repeat_en,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [DW-1:0] D_LAST      = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic          s1;
  logic          s2;
  logic [DW-1:0] dcnt;
  logic          settle;
  logic          rise_evt;
  logic          fall_evt;

  rpt_state_t    state;
  rpt_state_t    state_next;
  logic [RW-1:0] rcnt;
  logic [RW-1:0] rcnt_next;
  logic          fire_next;

  // settle marks the edge on which level flips; press/release and the FSM key off it
  assign settle   = (s2 != level) && (dcnt == D_LAST);
  assign rise_evt = settle & s2;
  assign fall_evt = settle & ~s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1            <= 1'b0;
      s2            <= 1'b0;
      dcnt          <= '0;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      s1            <= btn_in;
      s2            <= s1;
      press         <= rise_evt;
      release_pulse <= fall_evt;
      if (s2 == level) begin
        dcnt <= '0;
      end else if (dcnt == D_LAST) begin
        level <= s2;
        dcnt  <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      rcnt         <= '0;
      repeat_pulse <= 1'b0;
    end else begin
      state        <= state_next;
      rcnt         <= rcnt_next;
      repeat_pulse <= fire_next;
    end
  end

  // A falling level always beats a repeat due on the same edge
  always_comb begin
    state_next = state;
    rcnt_next  = rcnt;
    fire_next  = 1'b0;
    case (state)
      IDLE: begin
        rcnt_next = '0;
        if (repeat_en && rise_evt) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (fall_evt) begin
          state_next = IDLE;
          rcnt_next  = '0;
        end else if (rcnt == DELAY_LAST) begin
          state_next = RPT;
          rcnt_next  = '0;
          fire_next  = 1'b1;
        end else begin
          rcnt_next = rcnt + 1'b1;
        end
      end
      RPT: begin
        if (fall_evt) begin
          state_next = IDLE;
          rcnt_next  = '0;
        end else if (rcnt == PERIOD_LAST) begin
          rcnt_next = '0;
          fire_next = 1'b1;
        end else begin
          rcnt_next = rcnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        rcnt_next  = '0;
      end
    endcase
  end

endmodule

// File: rtl/button_bank.sv
// Bank of independent pushbutton channels feeding the game controller; the
// top level only merges the per-channel pulses into action and any_press.
module button_bank
  import input_pkg::*;
#(
  parameter int               N_BTN           = 5,
  parameter int               DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int               REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
  parameter int               REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT,
  parameter logic [N_BTN-1:0] REPEAT_MASK     = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] repeat_pulse,
  output logic [N_BTN-1:0] action,
  output logic             any_press
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_channel (
      .clk          (clk),
      .reset        (reset),
      .btn_in       (btn_in[i]),
      .repeat_en    (REPEAT_MASK[i]),
      .level        (level[i]),
      .press        (press[i]),
      .release_pulse(release_pulse[i]),
      .repeat_pulse (repeat_pulse[i])
    );
  end

  assign action    = press | repeat_pulse;
  assign any_press = |press;

endmodule

// File: tb/tb_button_bank.sv
// Directed bench for button_bank with short timing constants; inputs are
// driven and outputs sampled on the falling clock edge.
module tb_button_bank;

  localparam int         N_BTN = 3;
  localparam logic [2:0] MASK  = 3'b011;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] btn_in;
  logic [2:0] level;
  logic [2:0] press;
  logic [2:0] release_pulse;
  logic [2:0] repeat_pulse;
  logic [2:0] action;
  logic       any_press;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  button_bank #(
    .N_BTN          (N_BTN),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3),
    .REPEAT_MASK    (MASK)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_in       (btn_in),
    .level        (level),
    .press        (press),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse),
    .action       (action),
    .any_press    (any_press)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [15:0] obs;
    reset  = 1'b1;
    btn_in = 3'b000;
    for (int s = 1; s <= 5; s++) begin
      if (s == 4) reset = 1'b0;
      step();
      obs = {level, press, release_pulse, repeat_pulse, action, any_press};
      vectors++;
      if (obs !== 16'd0) begin
        $display("FAIL reset_outputs s=%0d: got %b expected %b", s, obs, 16'd0);
        miscompares++;
      end
    end
  endtask

  task automatic test_press_latency();
    logic [1:0] obs, exp;
    logic [2:0] obs3, exp3;
    btn_in[0] = 1'b1;
    for (int s = 1; s <= 8; s++) begin
      step();
      obs = {level[0], press[0]};
      exp = {s >= 6, s == 6};
      vectors++;
      if (obs !== exp) begin
        $display("FAIL press_latency s=%0d: {level,press} got %b expected %b", s, obs, exp);
        miscompares++;
      end
    end
    btn_in[0] = 1'b0;
    for (int s = 1; s <= 8; s++) begin
      step();
      obs3 = {level[0], release_pulse[0], repeat_pulse[0]};
      exp3 = {s < 6, s == 6, 1'b0};
      vectors++;
      if (obs3 !== exp3) begin
        $display("FAIL release_latency s=%0d: {level,release,repeat} got %b expected %b", s, obs3, exp3);
        miscompares++;
      end
    end
    repeat (6) step();
  endtask

  task automatic test_bounce();
    logic [1:0] obs, exp;
    for (int r = 0; r < 4; r++) begin
      for (int b = 0; b < 4; b++) begin
        btn_in[0] = (b != 3);
        step();
        obs = {level[0], press[0]};
        vectors++;
        if (obs !== 2'b00) begin
          $display("FAIL bounce r=%0d b=%0d: {level,press} got %b expected 00", r, b, obs);
          miscompares++;
        end
      end
    end
    btn_in[0] = 1'b1;
    for (int s = 1; s <= 8; s++) begin
      step();
      obs = {level[0], press[0]};
      exp = {s >= 6, s == 6};
      vectors++;
      if (obs !== exp) begin
        $display("FAIL bounce_settle s=%0d: {level,press} got %b expected %b", s, obs, exp);
        miscompares++;
      end
    end
    btn_in[0] = 1'b0;
    repeat (10) step();
  endtask

  task automatic test_repeat();
    logic [2:0] obs, exp;
    logic       p, r;
    int         act_count = 0;
    btn_in[1] = 1'b1;
    for (int s = 1; s <= 26; s++) begin
      step();
      p   = (s == 6);
      r   = (s == 16) || (s == 19) || (s == 22) || (s == 25);
      obs = {press[1], repeat_pulse[1], action[1]};
      exp = {p, r, p | r};
      if (action[1] === 1'b1) act_count++;
      vectors++;
      if (obs !== exp) begin
        $display("FAIL repeat_train s=%0d: {press,repeat,action} got %b expected %b", s, obs, exp);
        miscompares++;
      end
    end
    vectors++;
    if (act_count !== 5) begin
      $display("FAIL repeat_action_count: got %0d expected 5", act_count);
      miscompares++;
    end
  endtask

  task automatic test_release_race();
    logic [2:0] obs, exp;
    repeat (2) step();
    vectors++;
    if (repeat_pulse[1] !== 1'b1) begin
      $display("FAIL race_prior_repeat: got %b expected 1", repeat_pulse[1]);
      miscompares++;
    end
    btn_in[1] = 1'b0;
    for (int s = 1; s <= 8; s++) begin
      step();
      obs = {level[1], release_pulse[1], repeat_pulse[1]};
      exp = {s < 6, s == 6, s == 3};
      vectors++;
      if (obs !== exp) begin
        $display("FAIL release_race s=%0d: {level,release,repeat} got %b expected %b", s, obs, exp);
        miscompares++;
      end
    end
    for (int s = 1; s <= 12; s++) begin
      step();
      obs = {level[1], release_pulse[1], repeat_pulse[1]};
      vectors++;
      if (obs !== 3'b000) begin
        $display("FAIL race_idle s=%0d: {level,release,repeat} got %b expected 000", s, obs);
        miscompares++;
      end
    end
  endtask

  task automatic test_no_repeat();
    logic [1:0] obs, exp;
    btn_in[2] = 1'b1;
    for (int s = 1; s <= 36; s++) begin
      step();
      obs = {press[2], repeat_pulse[2]};
      exp = {s == 6, 1'b0};
      vectors++;
      if (obs !== exp) begin
        $display("FAIL masked_hold s=%0d: {press,repeat} got %b expected %b", s, obs, exp);
        miscompares++;
      end
    end
    btn_in[2] = 1'b0;
    for (int s = 1; s <= 8; s++) begin
      step();
      obs = {level[2], release_pulse[2]};
      exp = {s < 6, s == 6};
      vectors++;
      if (obs !== exp) begin
        $display("FAIL masked_release s=%0d: {level,release} got %b expected %b", s, obs, exp);
        miscompares++;
      end
    end
    repeat (4) step();
  endtask

  task automatic test_simultaneous_reset();
    logic [3:0]  obs4, exp4;
    logic [15:0] obs16;
    logic [8:0]  obs9, exp9;
    btn_in[1:0] = 2'b11;
    for (int s = 1; s <= 8; s++) begin
      step();
      obs4 = {press, any_press};
      exp4 = {(s == 6) ? 3'b011 : 3'b000, s == 6};
      vectors++;
      if (obs4 !== exp4) begin
        $display("FAIL simultaneous s=%0d: {press,any_press} got %b expected %b", s, obs4, exp4);
        miscompares++;
      end
    end
    reset = 1'b1;
    for (int s = 1; s <= 2; s++) begin
      step();
      obs16 = {level, press, release_pulse, repeat_pulse, action, any_press};
      vectors++;
      if (obs16 !== 16'd0) begin
        $display("FAIL midhold_reset s=%0d: got %b expected %b", s, obs16, 16'd0);
        miscompares++;
      end
    end
    reset = 1'b0;
    for (int s = 1; s <= 8; s++) begin
      step();
      obs9 = {level[1:0], press, release_pulse, any_press};
      exp9 = {(s >= 6) ? 2'b11 : 2'b00, (s == 6) ? 3'b011 : 3'b000, 3'b000, s == 6};
      vectors++;
      if (obs9 !== exp9) begin
        $display("FAIL repress_after_reset s=%0d: {level,press,release,any} got %b expected %b", s, obs9, exp9);
        miscompares++;
      end
    end
    btn_in = 3'b000;
    repeat (12) step();
  endtask

  initial begin
    test_reset();
    test_press_latency();
    test_bounce();
    test_repeat();
    test_release_race();
    test_no_repeat();
    test_simultaneous_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
